// File: rtl/mgmt_gpio_flash_sequencer.sv
// rtl/mgmt_gpio_flash_sequencer.sv - boot sequencer: SPI flash header read, then gpio blink with status byte.
// Optional MGMT_CHECK_ECHO_EN: checkbits_hi echoes checkbits_lo + 1 instead of the blink count.
module mgmt_gpio_flash_sequencer #(
  parameter int          CLK_DIV    = 2,
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  parameter int          DELAY_W    = 16
) (
  input  logic       clock,
  input  logic       reset,
  output logic       flash_csb,
  output logic       flash_clk,
  output logic       flash_io0,
  input  logic       flash_io1,
  output logic       gpio,
  input  logic [7:0] checkbits_lo,
  output logic [7:0] checkbits_hi,
  output logic       done
);

  localparam int          DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [31:0] CMD_WORD = {8'h03, FLASH_ADDR};

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_READ, S_BLINK_HI, S_BLINK_LO, S_DONE
  } state_t;

  state_t             r_state, w_state;
  logic               r_csb, w_csb;
  logic               r_sck, w_sck;
  logic               r_io0, w_io0;
  logic               r_gpio, w_gpio;
  logic               r_done, w_done;
  logic               r_tail, w_tail;
  logic [DIV_W-1:0]   r_div, w_div;
  logic [4:0]         r_bit, w_bit;
  logic [31:0]        r_shift, w_shift;
  logic [7:0]         r_n, w_n;
  logic [7:0]         r_blinks, w_blinks;
  logic [DELAY_W-1:0] r_delay, w_delay;
  logic [DELAY_W-1:0] r_dcnt, w_dcnt;
  logic [DELAY_W-1:0] w_hdr_d;
  logic               w_div_end;

  assign w_hdr_d   = DELAY_W'(r_shift[23:8]);
  assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_csb    <= 1'b1;
      r_sck    <= 1'b0;
      r_io0    <= 1'b0;
      r_gpio   <= 1'b0;
      r_done   <= 1'b0;
      r_tail   <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_n      <= '0;
      r_blinks <= '0;
      r_delay  <= DELAY_W'(1);
      r_dcnt   <= '0;
    end else begin
      r_state  <= w_state;
      r_csb    <= w_csb;
      r_sck    <= w_sck;
      r_io0    <= w_io0;
      r_gpio   <= w_gpio;
      r_done   <= w_done;
      r_tail   <= w_tail;
      r_div    <= w_div;
      r_bit    <= w_bit;
      r_shift  <= w_shift;
      r_n      <= w_n;
      r_blinks <= w_blinks;
      r_delay  <= w_delay;
      r_dcnt   <= w_dcnt;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_csb    = r_csb;
    w_sck    = r_sck;
    w_io0    = r_io0;
    w_gpio   = r_gpio;
    w_done   = r_done;
    w_tail   = r_tail;
    w_div    = r_div;
    w_bit    = r_bit;
    w_shift  = r_shift;
    w_n      = r_n;
    w_blinks = r_blinks;
    w_delay  = r_delay;
    w_dcnt   = r_dcnt;
    case (r_state)
      S_IDLE: begin
        w_state = S_CMD;
        w_csb   = 1'b0;
        w_sck   = 1'b0;
        w_io0   = CMD_WORD[31];
        w_shift = CMD_WORD << 1;
        w_div   = '0;
        w_bit   = '0;
        w_tail  = 1'b0;
      end
      S_CMD, S_READ: begin
        if (r_tail) begin
          // csb hold after the last falling edge, then decode the header
          if (w_div_end) begin
            w_csb    = 1'b1;
            w_n      = r_shift[31:24];
            w_delay  = (w_hdr_d == '0) ? DELAY_W'(1) : w_hdr_d;
            w_blinks = '0;
            w_dcnt   = '0;
            if (r_shift[31:24] == 8'd0) begin
              w_state = S_DONE;
              w_done  = 1'b1;
            end else begin
              w_state = S_BLINK_HI;
              w_gpio  = 1'b1;
            end
          end else begin
            w_div = r_div + 1'b1;
          end
        end else if (w_div_end) begin
          w_div = '0;
          w_sck = ~r_sck;
          if (!r_sck) begin
            if (r_state == S_READ) w_shift = {r_shift[30:0], flash_io1};
          end else begin
            w_bit = r_bit + 5'd1;
            if (r_state == S_CMD) begin
              w_io0   = r_shift[31];
              w_shift = r_shift << 1;
              if (r_bit == 5'd31) w_state = S_READ;
            end else if (r_bit == 5'd31) begin
              w_tail = 1'b1;
            end
          end
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      S_BLINK_HI: begin
        if (r_dcnt == r_delay - DELAY_W'(1)) begin
          w_gpio   = 1'b0;
          w_dcnt   = '0;
          w_state  = S_BLINK_LO;
          w_blinks = (r_blinks == 8'hFF) ? 8'hFF : r_blinks + 8'd1;
        end else begin
          w_dcnt = r_dcnt + DELAY_W'(1);
        end
      end
      S_BLINK_LO: begin
        if (r_dcnt == r_delay - DELAY_W'(1)) begin
          w_dcnt = '0;
          if (r_blinks < r_n) begin
            w_state = S_BLINK_HI;
            w_gpio  = 1'b1;
          end else begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end
        end else begin
          w_dcnt = r_dcnt + DELAY_W'(1);
        end
      end
      S_DONE: begin
        w_gpio = 1'b0;
        w_csb  = 1'b1;
        w_done = 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign flash_csb = r_csb;
  assign flash_clk = r_sck;
  assign flash_io0 = r_io0;
  assign gpio      = r_gpio;
  assign done      = r_done;

`ifdef MGMT_CHECK_ECHO_EN
  logic [7:0] r_echo;
  always_ff @(posedge clock) begin
    if (reset) r_echo <= '0;
    else       r_echo <= checkbits_lo + 8'd1;
  end
  assign checkbits_hi = r_echo;
`else
  logic w_unused_lo;
  assign w_unused_lo  = ^checkbits_lo;
  assign checkbits_hi = r_blinks;
`endif

endmodule

// File: tb/tb_mgmt_gpio_flash_sequencer.sv
// tb/tb_mgmt_gpio_flash_sequencer.sv - scoreboard bench: flash model, gpio/done event monitor.
module tb_mgmt_gpio_flash_sequencer;

  localparam int EV_CMD = 0, EV_RISE = 1, EV_FALL = 2, EV_DONE = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flash_csb, flash_clk, flash_io0, gpio, done;
  logic       flash_io1 = 1'b0;
  logic [7:0] checkbits_lo = 8'h00;
  logic [7:0] checkbits_hi;

  int total = 0;
  int bad = 0;
  ev_t sb[$];

  logic [31:0] hdr = 32'h0;
  logic        aborting = 1'b1;
  int          rises = 0;
  int          pulses = 0;

  always #5 clock = ~clock;

  mgmt_gpio_flash_sequencer dut (
    .clock(clock), .reset(reset),
    .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0(flash_io0), .flash_io1(flash_io1),
    .gpio(gpio), .checkbits_lo(checkbits_lo),
    .checkbits_hi(checkbits_hi), .done(done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] cb_exp(input int k);
`ifdef MGMT_CHECK_ECHO_EN
    return 8'h01;
`else
    return 8'(k);
`endif
  endfunction

  task automatic push(input int kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic push_seq(input int n, input int d);
    int de;
    de = (d == 0) ? 1 : d;
    push(EV_CMD, 32'h03000000);
    for (int k = 1; k <= n; k++) begin
      push(EV_RISE, (k == 1) ? 32'd0 : 32'(de));
      push(EV_FALL, {8'h00, 16'(de), cb_exp(k)});
    end
    push(EV_DONE, {6'b0, 1'b1, 1'b0, cb_exp(n), (n == 0) ? 16'd0 : 16'(de)});
  endtask

  task automatic emit(input int kind, input logic [31:0] val);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event kind=%0d got=%h want=none", kind, val);
    end else begin
      e = sb.pop_front();
      chk($sformatf("ev_kind(val=%h)", val), 32'(kind), 32'(e.kind));
      chk($sformatf("ev_val(kind=%0d)", e.kind), val, e.val);
    end
  endtask

  // Flash model (mode 0) and gpio/done event monitor, all sampled on the falling system edge
  initial begin
    logic p_csb, p_sck, p_gpio, p_done;
    logic [31:0] cmd;
    int cyc, hi;
    p_csb = 1'b1; p_sck = 1'b0; p_gpio = 1'b0; p_done = 1'b0;
    cmd = '0; cyc = 0; hi = 0;
    forever begin
      @(negedge clock);
      if (aborting || reset) begin
        rises = 0; pulses = 0; cmd = '0; flash_io1 = 1'b0;
      end else begin
        cyc++;
        hi++;
        if (flash_csb && !p_csb) cyc = 0;
        if (flash_csb) begin
          rises = 0; cmd = '0; flash_io1 = 1'b0;
        end else if (flash_clk && !p_sck) begin
          if (rises < 32) cmd = {cmd[30:0], flash_io0};
          rises++;
          if (rises == 32) emit(EV_CMD, cmd);
        end else if (!flash_clk && p_sck) begin
          if (rises >= 32 && rises < 64) flash_io1 = hdr[63 - rises];
        end
        if (!flash_csb && p_csb) pulses = 0;
        if (gpio && !p_gpio) begin
          emit(EV_RISE, 32'(cyc));
          hi = 0;
          pulses++;
        end
        if (!gpio && p_gpio) begin
          emit(EV_FALL, {8'h00, 16'(hi), checkbits_hi});
          cyc = 0;
        end
        if (done && !p_done) emit(EV_DONE, {6'b0, flash_csb, gpio, checkbits_hi, 16'(cyc)});
      end
      p_csb = flash_csb; p_sck = flash_clk; p_gpio = gpio; p_done = done;
    end
  end

  task automatic do_reset(input int cycles, input string nm);
    @(posedge clock);
    #1;
    aborting = 1'b1;
    reset    = 1'b1;
    repeat (cycles) @(posedge clock);
    #1;
    chk({nm, "_csb"},  32'(flash_csb), 32'd1);
    chk({nm, "_clk"},  32'(flash_clk), 32'd0);
    chk({nm, "_io0"},  32'(flash_io0), 32'd0);
    chk({nm, "_gpio"}, 32'(gpio), 32'd0);
    chk({nm, "_cb"},   32'(checkbits_hi), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    aborting = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=done0 want=done1", nm);
    end
    repeat (3) @(posedge clock);
    #1;
    chk({nm, "_post_csb"},  32'(flash_csb), 32'd1);
    chk({nm, "_post_gpio"}, 32'(gpio), 32'd0);
    chk({nm, "_post_done"}, 32'(done), 32'd1);
    chk({nm, "_sb_empty"},  32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    // 10 pulses of 100 clocks high / 100 low
    hdr = 32'h0A006400;
    push_seq(10, 100);
    do_reset(3, "por");
    wait_done(4000, "n10");

    // N == 0: done alongside csb rise, no pulse
    hdr = 32'h00FFFF00;
    push_seq(0, 0);
    do_reset(2, "n0");
    wait_done(1000, "n0");

    // D == 0 behaves as D == 1
    hdr = 32'h03000000;
    push_seq(3, 0);
    do_reset(2, "d0");
    wait_done(1000, "d0");

    // reset during READ, bit 20
    hdr = 32'h02000500;
    push(EV_CMD, 32'h03000000);
    do_reset(2, "t4");
    n = 0;
    while (rises < 52 && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("rd_reach_bit20", 32'(rises), 32'd52);
    do_reset(1, "rd_abort");
    push_seq(2, 5);
    wait_done(1000, "rd_restart");

    // reset during the 5th BLINK_HI
    hdr = 32'h06000400;
    push(EV_CMD, 32'h03000000);
    for (int k = 1; k <= 4; k++) begin
      push(EV_RISE, (k == 1) ? 32'd0 : 32'd4);
      push(EV_FALL, {8'h00, 16'd4, cb_exp(k)});
    end
    push(EV_RISE, 32'd4);
    do_reset(2, "t5");
    n = 0;
    while (!(pulses == 5 && gpio) && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("bl_reach_5th", 32'(pulses), 32'd5);
    do_reset(1, "bl_abort");
    push_seq(6, 4);
    wait_done(1000, "bl_restart");

`ifdef MGMT_CHECK_ECHO_EN
    @(posedge clock);
    #1;
    checkbits_lo = 8'h41;
    @(posedge clock);
    #1;
    chk("echo_41", 32'(checkbits_hi), 32'h42);
    checkbits_lo = 8'hFF;
    @(posedge clock);
    #1;
    chk("echo_ff", 32'(checkbits_hi), 32'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
